// File: rtl/icache_pkg.sv
// Purpose: shared types and derived-width helpers for the direct-mapped instruction cache.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package icache_pkg;

  localparam int INSTR_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_FILL = 2'd2
  } fill_state_e;

  function automatic int off_w(input int line_bytes);
    return $clog2(line_bytes);
  endfunction

  function automatic int idx_w(input int num_lines);
    return $clog2(num_lines);
  endfunction

  function automatic int tag_w(input int addr_w, input int line_bytes, input int num_lines);
    return addr_w - off_w(line_bytes) - idx_w(num_lines);
  endfunction

  // Word-in-line index width; kept at least 1 bit so single-word lines still elaborate.
  function automatic int word_w(input int line_bytes);
    return (line_bytes > 4) ? $clog2(line_bytes / 4) : 1;
  endfunction

endpackage

// File: rtl/icache_refill_fsm.sv
// Purpose: line-refill sequencer: request/grant handshake, beat counting, flush abort.
// Latency: REQ asserted the cycle after start; line validated on the edge of the last beat.
// Backpressure: holds mem_req/fill_addr until mem_gnt; waits indefinitely for beats.
// Ports: clk/rst_n; start+start_addr (line-aligned miss address); flush; mem_gnt/mem_rvalid
//        from the bus; idle, mem_req, fill_addr, wr_en/wr_beat (data write), validate (tag+valid).
module icache_refill_fsm
  import icache_pkg::*;
#(
  parameter int ADDR_W     = 64,
  parameter int LINE_BYTES = 16
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            start,
  input  logic [ADDR_W-1:0]               start_addr,
  input  logic                            flush,
  input  logic                            mem_gnt,
  input  logic                            mem_rvalid,
  output logic                            idle,
  output logic                            mem_req,
  output logic [ADDR_W-1:0]               fill_addr,
  output logic                            wr_en,
  output logic [word_w(LINE_BYTES)-1:0]   wr_beat,
  output logic                            validate
);

  localparam int WORDS  = LINE_BYTES / 4;
  localparam int WORD_W = word_w(LINE_BYTES);

  fill_state_e       state_q, state_d;
  logic [WORD_W-1:0] beat_q, beat_d;
  logic              abort_q, abort_d;
  logic [ADDR_W-1:0] addr_q, addr_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      beat_q  <= '0;
      abort_q <= 1'b0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      abort_q <= abort_d;
      addr_q  <= addr_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    beat_d   = beat_q;
    abort_d  = abort_q;
    addr_d   = addr_q;
    mem_req  = 1'b0;
    wr_en    = 1'b0;
    validate = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_REQ;
          addr_d  = start_addr;
          abort_d = 1'b0;
        end
      end
      ST_REQ: begin
        mem_req = 1'b1;
        if (flush) abort_d = 1'b1;
        // Grant cycle carries no data; beats start the following cycle.
        if (mem_gnt) begin
          state_d = ST_FILL;
          beat_d  = '0;
        end
      end
      ST_FILL: begin
        if (flush) abort_d = 1'b1;
        if (mem_rvalid) begin
          wr_en = 1'b1;
          if (beat_q == WORD_W'(WORDS - 1)) begin
            // A flush on the last beat itself also blocks validation.
            validate = ~abort_q & ~flush;
            state_d  = ST_IDLE;
            beat_d   = '0;
            abort_d  = 1'b0;
          end else begin
            beat_d = beat_q + WORD_W'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign idle      = (state_q == ST_IDLE);
  assign fill_addr = addr_q;
  assign wr_beat   = beat_q;

endmodule

// File: rtl/instruction_cache_dm.sv
// Purpose: direct-mapped instruction cache between fetch and the memory bus.
// Latency: hits return combinationally in the same cycle; misses stall until the line is filled.
// Backpressure: STALL holds fetch on miss, refill or flush; refill waits on MEM_GNT / MEM_RVALID.
// Ports: CLK, RESET_N; PC/FETCH_REQ/FLUSH from fetch; INSTRUCTION/INSTR_VALID/STALL to fetch;
//        MEM_REQ/MEM_ADDR/MEM_GNT/MEM_RVALID/MEM_RDATA refill bus.
// Optional: ICACHE_PERF_CNT_EN adds saturating HIT_COUNT / MISS_COUNT outputs.
module instruction_cache_dm
  import icache_pkg::*;
#(
  parameter int ADDR_W     = 64,
  parameter int LINE_BYTES = 16,
  parameter int NUM_LINES  = 64
) (
  input  logic               CLK,
  input  logic               RESET_N,
  input  logic [ADDR_W-1:0]  PC,
  input  logic               FETCH_REQ,
  input  logic               FLUSH,
  output logic [31:0]        INSTRUCTION,
  output logic               INSTR_VALID,
  output logic               STALL,
  output logic               MEM_REQ,
  output logic [ADDR_W-1:0]  MEM_ADDR,
  input  logic               MEM_GNT,
  input  logic               MEM_RVALID,
  input  logic [31:0]        MEM_RDATA
`ifdef ICACHE_PERF_CNT_EN
  ,
  output logic [31:0]        HIT_COUNT,
  output logic [31:0]        MISS_COUNT
`endif
);

  localparam int WORDS  = LINE_BYTES / 4;
  localparam int OFF_W  = off_w(LINE_BYTES);
  localparam int IDX_W  = idx_w(NUM_LINES);
  localparam int TAG_W  = tag_w(ADDR_W, LINE_BYTES, NUM_LINES);
  localparam int WORD_W = word_w(LINE_BYTES);

  logic [NUM_LINES-1:0] valid_q, valid_d;
  logic [TAG_W-1:0]     tag_mem  [NUM_LINES];
  logic [INSTR_W-1:0]   data_mem [NUM_LINES][WORDS];

  logic [IDX_W-1:0]  pc_idx, fill_idx;
  logic [TAG_W-1:0]  pc_tag, fill_tag;
  logic [WORD_W-1:0] pc_word, wr_beat;
  logic [ADDR_W-1:0] fill_addr;
  logic              hit, start, fsm_idle, wr_en, validate;

  assign pc_idx   = PC[OFF_W+IDX_W-1:OFF_W];
  assign pc_tag   = PC[ADDR_W-1:OFF_W+IDX_W];
  assign pc_word  = WORD_W'(PC[OFF_W-1:0] >> 2);
  assign fill_idx = fill_addr[OFF_W+IDX_W-1:OFF_W];
  assign fill_tag = fill_addr[ADDR_W-1:OFF_W+IDX_W];

  assign hit   = FETCH_REQ & fsm_idle & valid_q[pc_idx] & (tag_mem[pc_idx] == pc_tag);
  assign start = FETCH_REQ & fsm_idle & ~hit;

  icache_refill_fsm #(
    .ADDR_W     (ADDR_W),
    .LINE_BYTES (LINE_BYTES)
  ) u_refill (
    .clk        (CLK),
    .rst_n      (RESET_N),
    .start      (start),
    .start_addr ({PC[ADDR_W-1:OFF_W], {OFF_W{1'b0}}}),
    .flush      (FLUSH),
    .mem_gnt    (MEM_GNT),
    .mem_rvalid (MEM_RVALID),
    .idle       (fsm_idle),
    .mem_req    (MEM_REQ),
    .fill_addr  (fill_addr),
    .wr_en      (wr_en),
    .wr_beat    (wr_beat),
    .validate   (validate)
  );

  // Flush takes priority; validate is already suppressed when flush is high.
  always_comb begin
    valid_d = valid_q;
    if (validate) valid_d[fill_idx] = 1'b1;
    if (FLUSH)    valid_d = '0;
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) valid_q <= '0;
    else          valid_q <= valid_d;
  end

  // Storage arrays carry no reset; the valid bits alone gate their use.
  always_ff @(posedge CLK) begin
    if (wr_en)    data_mem[fill_idx][wr_beat] <= MEM_RDATA;
    if (validate) tag_mem[fill_idx]           <= fill_tag;
  end

  assign INSTRUCTION = data_mem[pc_idx][pc_word];
  assign INSTR_VALID = hit;
  assign MEM_ADDR    = fill_addr;
  // Gated by reset so the fetch stage sees no stall while the cache is held in reset.
  assign STALL       = RESET_N & ((FETCH_REQ & ~hit) | ~fsm_idle | FLUSH);

`ifdef ICACHE_PERF_CNT_EN
  logic [31:0] hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d;

  always_comb begin
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if (hit && (hit_cnt_q != '1))    hit_cnt_d  = hit_cnt_q + 32'd1;
    if (start && (miss_cnt_q != '1)) miss_cnt_d = miss_cnt_q + 32'd1;
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign HIT_COUNT  = hit_cnt_q;
  assign MISS_COUNT = miss_cnt_q;
`endif

endmodule

// File: tb/tb_instruction_cache_dm.sv
// Bench for instruction_cache_dm: directed fetch/refill scenarios, checked every cycle against
// a cache model that tracks which line address each index holds and what memory contains.
module tb_instruction_cache_dm;

  logic        CLK = 1'b0;
  logic        RESET_N = 1'b1;
  logic [63:0] PC = '0;
  logic        FETCH_REQ = 1'b0;
  logic        FLUSH = 1'b0;
  logic [31:0] INSTRUCTION;
  logic        INSTR_VALID;
  logic        STALL;
  logic        MEM_REQ;
  logic [63:0] MEM_ADDR;
  logic        MEM_GNT = 1'b0;
  logic        MEM_RVALID = 1'b0;
  logic [31:0] MEM_RDATA = '0;
`ifdef ICACHE_PERF_CNT_EN
  logic [31:0] HIT_COUNT, MISS_COUNT;
`endif

  instruction_cache_dm dut (
    .CLK         (CLK),
    .RESET_N     (RESET_N),
    .PC          (PC),
    .FETCH_REQ   (FETCH_REQ),
    .FLUSH       (FLUSH),
    .INSTRUCTION (INSTRUCTION),
    .INSTR_VALID (INSTR_VALID),
    .STALL       (STALL),
    .MEM_REQ     (MEM_REQ),
    .MEM_ADDR    (MEM_ADDR),
    .MEM_GNT     (MEM_GNT),
    .MEM_RVALID  (MEM_RVALID),
    .MEM_RDATA   (MEM_RDATA)
`ifdef ICACHE_PERF_CNT_EN
    ,
    .HIT_COUNT   (HIT_COUNT),
    .MISS_COUNT  (MISS_COUNT)
`endif
  );

  always #5 CLK = ~CLK;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Backing memory: the first line holds a short program, everything else is address-derived.
  function automatic logic [31:0] memfn(input logic [63:0] a);
    logic [31:0] lo;
    lo = a[31:0];
    case (a)
      64'h0:   return 32'h00500093;
      64'h4:   return 32'h00000013;
      64'h8:   return 32'h00000013;
      64'hC:   return 32'h0000006F;
      default: return (lo * 32'h9E3779B1) ^ 32'h0BADF00D;
    endcase
  endfunction

  function automatic int midx(input logic [63:0] a);
    return int'((a >> 4) & 64'd63);
  endfunction

  function automatic logic [63:0] mline_of(input logic [63:0] a);
    return a & ~64'hF;
  endfunction

  // Model: which line address each index holds, plus the outstanding refill.
  logic        mvalid [64];
  logic [63:0] mline  [64];
  logic        busy = 1'b0, granted = 1'b0, aborted = 1'b0;
  logic [63:0] fill_line = '0;
  int          beats = 0;
  logic [31:0] hits = '0, misses = '0;

  initial for (int i = 0; i < 64; i++) mvalid[i] = 1'b0;

  function automatic logic model_hit();
    return FETCH_REQ && !busy && mvalid[midx(PC)] && (mline[midx(PC)] == mline_of(PC));
  endfunction

  always @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      busy    <= 1'b0;
      granted <= 1'b0;
      aborted <= 1'b0;
      beats   <= 0;
      hits    <= '0;
      misses  <= '0;
      for (int i = 0; i < 64; i++) mvalid[i] <= 1'b0;
    end else if (!busy) begin
      if (model_hit()) begin
        if (hits != 32'hFFFF_FFFF) hits <= hits + 32'd1;
      end else if (FETCH_REQ) begin
        busy      <= 1'b1;
        granted   <= 1'b0;
        aborted   <= 1'b0;
        beats     <= 0;
        fill_line <= mline_of(PC);
        if (misses != 32'hFFFF_FFFF) misses <= misses + 32'd1;
      end
      if (FLUSH) for (int i = 0; i < 64; i++) mvalid[i] <= 1'b0;
    end else begin
      if (FLUSH) begin
        aborted <= 1'b1;
        for (int i = 0; i < 64; i++) mvalid[i] <= 1'b0;
      end
      if (!granted) begin
        if (MEM_GNT) granted <= 1'b1;
      end else if (MEM_RVALID) begin
        if (beats == 3) begin
          busy  <= 1'b0;
          beats <= 0;
          if (!aborted && !FLUSH) begin
            mvalid[midx(fill_line)] <= 1'b1;
            mline[midx(fill_line)]  <= fill_line;
          end
        end else begin
          beats <= beats + 1;
        end
      end
    end
  end

  // Per-cycle comparison against the model, half a cycle after the edge.
  always @(negedge CLK) begin
    chk("instr_valid", INSTR_VALID, model_hit());
    if (model_hit()) chk("instruction", INSTRUCTION, memfn(PC & ~64'h3));
    chk("stall", STALL, RESET_N && ((FETCH_REQ && !model_hit()) || busy || FLUSH));
    chk("mem_req", MEM_REQ, RESET_N && busy && !granted);
    if (busy && !granted) chk("mem_addr", MEM_ADDR, fill_line);
`ifdef ICACHE_PERF_CNT_EN
    chk("hit_count", HIT_COUNT, hits);
    chk("miss_count", MISS_COUNT, misses);
`endif
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic wait_req();
    int n = 0;
    while (MEM_REQ !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk("req_seen", MEM_REQ, 1);
  endtask

  // Bus responder: optional grant delay with stray beats, then four beats; optional flush on one beat.
  task automatic do_fill(input int gnt_delay, input int flush_beat, output logic [63:0] addr);
    wait_req();
    addr = MEM_ADDR;
    for (int d = 0; d < gnt_delay; d++) begin
      MEM_RVALID = 1'b1;
      MEM_RDATA  = 32'hDEADBEEF;
      tick();
    end
    MEM_RVALID = 1'b0;
    MEM_GNT    = 1'b1;
    tick();
    MEM_GNT = 1'b0;
    for (int b = 0; b < 4; b++) begin
      MEM_RVALID = 1'b1;
      MEM_RDATA  = memfn(addr + 64'(4 * b));
      FLUSH      = (b == flush_beat);
      tick();
    end
    MEM_RVALID = 1'b0;
    FLUSH      = 1'b0;
  endtask

  initial begin
    #700000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  logic [63:0] a;

  initial begin
    FETCH_REQ = 1'b1;
    PC        = 64'h0;
    #2 RESET_N = 1'b0;
    tick();
    tick();
    // Reset state, with a fetch already pending.
    chk("rst_stall", STALL, 0);
    chk("rst_mem_req", MEM_REQ, 0);
    chk("rst_mem_addr", MEM_ADDR, 0);
    chk("rst_instr_valid", INSTR_VALID, 0);
`ifdef ICACHE_PERF_CNT_EN
    chk("rst_hit_count", HIT_COUNT, 0);
    chk("rst_miss_count", MISS_COUNT, 0);
`endif
    RESET_N = 1'b1;
    #1;
    // 1: cold miss on PC 0 and refill.
    chk("t1_cold_stall", STALL, 1);
    chk("t1_cold_no_req_yet", MEM_REQ, 0);
    do_fill(0, -1, a);
    chk("t1_addr", a, 64'h0);
    chk("t1_hit0_valid", INSTR_VALID, 1);
    chk("t1_hit0_data", INSTRUCTION, 32'h00500093);
    PC = 64'hC;
    #1;
    chk("t1_hitC_valid", INSTR_VALID, 1);
    chk("t1_hitC_data", INSTRUCTION, 32'h0000006F);
    tick();

    // 2: conflict miss on the same index evicts line 0.
    PC = 64'h400;
    do_fill(0, -1, a);
    chk("t2_addr", a, 64'h400);
    PC = 64'h0;
    #1;
    chk("t2_evicted_valid", INSTR_VALID, 0);
    chk("t2_evicted_stall", STALL, 1);
    do_fill(0, -1, a);
    chk("t2_refill_addr", a, 64'h0);

    // 3: delayed grant with stray beats; PC moves away during the refill.
    PC = 64'h14;
    tick();
    PC = 64'h0;
    do_fill(5, -1, a);
    chk("t3_addr", a, 64'h10);
    chk("t3_pc0_valid", INSTR_VALID, 1);
    chk("t3_pc0_data", INSTRUCTION, 32'h00500093);
    PC = 64'h14;
    #1;
    chk("t3_hit14_valid", INSTR_VALID, 1);
    chk("t3_hit14_data", INSTRUCTION, memfn(64'h14));
    tick();

    // 4: flush on beat 2 aborts the line and invalidates everything.
    PC = 64'h20;
    do_fill(0, 2, a);
    chk("t4_addr", a, 64'h20);
    chk("t4_idle_no_req", MEM_REQ, 0);
    chk("t4_aborted_miss", INSTR_VALID, 0);
    chk("t4_aborted_stall", STALL, 1);
    PC = 64'h0;
    #1;
    chk("t4_old_line_miss", INSTR_VALID, 0);
    do_fill(0, -1, a);

    // 5: reset in the middle of a fill.
    PC = 64'h30;
    wait_req();
    MEM_GNT = 1'b1;
    tick();
    MEM_GNT    = 1'b0;
    MEM_RVALID = 1'b1;
    MEM_RDATA  = 32'h11111111;
    tick();
    RESET_N = 1'b0;
    #1;
    chk("t5_req_dropped", MEM_REQ, 0);
    chk("t5_stall_low", STALL, 0);
    chk("t5_addr_zero", MEM_ADDR, 0);
    FETCH_REQ = 1'b0;
    tick();
    tick();
    RESET_N = 1'b1;
    tick();
    MEM_RVALID = 1'b0;
    FETCH_REQ  = 1'b1;
    PC         = 64'h0;
    #1;
    chk("t5_cold_stall", STALL, 1);
    chk("t5_cold_miss", INSTR_VALID, 0);
    do_fill(0, -1, a);

    // 6: one miss then three hit cycles; flush in idle.
    tick();
    PC = 64'h4;
    tick();
    PC = 64'h8;
    tick();
    FETCH_REQ = 1'b0;
    #1;
`ifdef ICACHE_PERF_CNT_EN
    chk("t6_miss_count", MISS_COUNT, 1);
    chk("t6_hit_count", HIT_COUNT, 3);
`endif
    FLUSH = 1'b1;
    #1;
    chk("t6_flush_stall", STALL, 1);
    tick();
    FLUSH = 1'b0;
`ifdef ICACHE_PERF_CNT_EN
    chk("t6_miss_after_flush", MISS_COUNT, 1);
    chk("t6_hit_after_flush", HIT_COUNT, 3);
`endif
    FETCH_REQ = 1'b1;
    PC        = 64'h0;
    #1;
    chk("t6_flushed_miss", INSTR_VALID, 0);
    FETCH_REQ = 1'b0;
    tick();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/instruction_cache_dm.md
Name: instruction_cache_dm

Overview:
Parametrised direct-mapped instruction cache replacing the flat preloaded fetch memory. Sits between the fetch stage (PC in, 32-bit instruction out) and the memory bus. Serves hits combinationally and stalls fetch on a miss. On a miss it refills one line from memory through a request/grant/beat handshake. Supports a full invalidate (flush) for self-modifying code and FENCE.I.

Parameters:
ADDR_W, 64, PC / bus address width
LINE_BYTES, 16, bytes per line; power of two, >= 4
NUM_LINES, 64, number of lines; power of two, >= 2
(derived) WORDS = LINE_BYTES/4; OFF_W = log2(LINE_BYTES); IDX_W = log2(NUM_LINES); TAG_W = ADDR_W-IDX_W-OFF_W

Ports:
CLK  in  1  clock, rising edge
RESET_N  in  1  asynchronous active-low reset
PC  in  ADDR_W  fetch address; bits [1:0] ignored
FETCH_REQ  in  1  fetch stage requests an instruction this cycle
FLUSH  in  1  invalidate all lines (single-cycle pulse)
INSTRUCTION  out  32  fetched instruction, little-endian word
INSTR_VALID  out  1  INSTRUCTION is valid for current PC (hit)
STALL  out  1  fetch must hold PC; high on miss, fill or flush
MEM_REQ  out  1  line-refill request
MEM_ADDR  out  ADDR_W  line-aligned refill address (low OFF_W bits zero)
MEM_GNT  in  1  bus accepted request (sampled while MEM_REQ high)
MEM_RVALID  in  1  one 32-bit refill beat present
MEM_RDATA  in  32  refill beat data

Behaviour:
- Lookup: index = PC[OFF_W+IDX_W-1:OFF_W]; tag = PC[ADDR_W-1:OFF_W+IDX_W]; word = PC[OFF_W-1:2]. Hit = FETCH_REQ & valid[index] & tag match & state==IDLE. Zero-latency: INSTR_VALID and INSTRUCTION combinational on hit.
- INSTRUCTION is don't-care when INSTR_VALID=0. The bench must not check it then.
- STALL = FETCH_REQ & ~hit, or state!=IDLE.
- FSM states: IDLE, REQ, FILL.
- IDLE -> REQ on FETCH_REQ miss. Latch index, tag and line address into fill registers.
- REQ: MEM_REQ=1 and MEM_ADDR stable until MEM_GNT=1 is sampled. Then go to FILL with beat counter = 0. The grant cycle is not a data cycle.
- FILL: each MEM_RVALID writes MEM_RDATA to data[fill_index][beat] and increments beat. Beats arrive in ascending word order.
- On the last beat (beat==WORDS-1): write tag, set valid (unless an abort is pending), return to IDLE.
- The line becomes a hit the cycle after the last beat. No critical-word-first forwarding.
- The PC may change during a fill. The fill completes for the latched address, and lookup resumes on the current PC.
- FLUSH in IDLE: all valid bits cleared at the next edge. STALL is high during the flush cycle.
- FLUSH in REQ or FILL: valid bits cleared. An abort flag is set so the in-flight line is not marked valid. Remaining beats are still consumed to keep the bus protocol intact.
- FLUSH coincident with the last beat: the line is not validated.
- Reset (asynchronous, any state): state=IDLE, all valid bits=0, beat=0, abort=0.
- Reset values of outputs: MEM_REQ=0, MEM_ADDR=0, INSTR_VALID=0, STALL=0.
- Data and tag arrays are not reset.
- Reset asserted mid-fill drops MEM_REQ immediately. Late beats after reset are ignored because the state is IDLE.
- MEM_RVALID outside FILL: ignored.

Optional Feature:
ICACHE_PERF_CNT_EN.
- When defined: adds outputs HIT_COUNT[31:0] and MISS_COUNT[31:0].
- HIT_COUNT increments per cycle with a hit. MISS_COUNT increments per IDLE->REQ transition.
- Both counters saturate at all-ones and reset to 0. FLUSH does not clear them.
- When undefined: the ports and counters are absent and behaviour is otherwise identical.

Decomposition:
- Shared package icache_pkg: FSM state enum (IDLE/REQ/FILL), the derived-width constant functions, and the instruction word width constant 32.
- One natural sub-module, icache_refill_fsm. It owns the state, beat counter, abort flag and bus handshake, and emits write-enable/beat-index/validate strobes.
- The top level holds the tag/valid/data arrays and the lookup logic.

Test Plan:
1. Reset, FETCH_REQ with PC=0x0 -> STALL=1. MEM_REQ with MEM_ADDR=0x0. After grant plus 4 beats 0x00500093,0x00000013,0x00000013,0x0000006F, PC=0x0 hits next cycle with INSTRUCTION=0x00500093; PC=0xC hits with 0x0000006F.
2. Conflict miss: fill 0x0, then PC=0x400 (same index, NUM_LINES=64, LINE_BYTES=16) -> refill to MEM_ADDR=0x400. Afterwards PC=0x0 misses again.
3. MEM_GNT delayed 5 cycles -> MEM_REQ and MEM_ADDR held constant for all 5 cycles. No beat is written before the grant.
4. FLUSH during beat 2 of a fill -> remaining beats consumed, FSM reaches IDLE. The same PC then misses. Previously valid lines also miss.
5. RESET_N low mid-fill -> MEM_REQ=0 and STALL=0 asynchronously. Stray MEM_RVALID ignored. Cold miss after reset release.
6. With ICACHE_PERF_CNT_EN: 1 miss and 3 hit cycles -> MISS_COUNT=1, HIT_COUNT=3. After FLUSH the counts are unchanged.
